uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single on-chip UART transmitter (FPGA_SERIAL_TX path) between NUM_REQ byte-stream requesters, e.g. Riscv151 console output and a debug/event reporter driven by the edge-detected buttons and rotary_decoder.
- Uses round-robin arbitration with a line lock, so text lines from different sources never interleave mid-line.
- Sits between the requesters and the uart_transmitter's ready/valid input, in the cpu_clk_g domain.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
EOL_CHAR, 8'h0A, byte that ends a locked line and releases the grant
MAX_BURST, 80, max bytes per grant before forced release (1..255)
IDLE_TIMEOUT, 1024, cycles the granted requester may hold valid low before forced release (>=2)

Ports:
clk  in  1  system clock (cpu_clk_g)
rst_b  in  1  asynchronous active-low reset
req_data  in  8*NUM_REQ  byte from requester i at bits [8i+7:8i]
req_valid  in  NUM_REQ  requester i has a byte
req_ready  out  NUM_REQ  byte of requester i accepted this cycle when req_valid[i] is also high
tx_data  out  8  byte to uart_transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  uart_transmitter can accept a byte
grant  out  NUM_REQ  one-hot current owner, all zero when idle
busy  out  1  high in GRANT state

Behaviour:
- Reset (asynchronous, rst_b=0):
  - state=IDLE, grant=0, busy=0.
  - rr pointer=0, meaning requester 0 has highest priority.
  - burst_cnt=0, idle_cnt=0.
  - tx_valid=0, req_ready=0.
- Reset mid-burst drops the byte in flight at the arbiter side. Requesters must re-present it.
- State machine, registered state {IDLE, GRANT}.
- IDLE:
  - tx_valid=0, req_ready=0.
  - If any req_valid is high, register the winner into grant and go to GRANT.
  - Winner is the first index i with req_valid[i]=1, searching from rr pointer upward and wrapping modulo NUM_REQ.
  - Arbitration latency is 1 cycle: the first byte can transfer in the cycle after the request is seen.
- GRANT (owner g):
  - Combinational pass-through: tx_data=req_data[g], tx_valid=req_valid[g], req_ready[g]=tx_ready.
  - All other req_ready bits are 0.
  - A transfer occurs when req_valid[g] and tx_ready are both high.
  - Per transfer: burst_cnt increments and idle_cnt clears.
  - Each cycle with req_valid[g]=0: idle_cnt increments, saturating.
- Release conditions, evaluated on the registered cycle; any one causes release:
  - (a) the transferred byte equals EOL_CHAR;
  - (b) the transfer makes burst_cnt reach MAX_BURST;
  - (c) idle_cnt reaches IDLE_TIMEOUT-1 with no transfer this cycle.
- On release:
  - next state=IDLE, grant=0, burst_cnt=0, idle_cnt=0.
  - rr pointer=(g+1) mod NUM_REQ.
  - There is always one IDLE cycle between grants.
- Simultaneous events:
  - EOL on the MAX_BURST byte counts as a single release.
  - Requests from non-owners during GRANT are ignored and held by the requesters; no starvation follows, because of the rr pointer advance.
- Owner lowering valid mid-line: the grant is kept until the timeout, so the line stays atomic.
- Counter widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - idle_cnt is $clog2(IDLE_TIMEOUT) bits.
  - Neither may wrap.
- tx_data is don't-care when tx_valid=0, but is driven 0 in IDLE.

Decomposition:
- Shared package holds:
  - state encoding localparams (ST_IDLE, ST_GRANT);
  - default EOL_CHAR;
  - a clog2 helper function.
- One sub-module is natural: rr_priority_picker (combinational). It takes a req vector and the rr pointer and returns a one-hot winner and its index. It is reusable for future MMIO arbitration.
- The counters and FSM stay in uart_tx_arbiter.

Test Plan:
- Single requester: req0 sends "AB\n" with tx_ready=1.
  - grant=01 one cycle after req_valid.
  - tx_data sequence 41,42,0A.
  - Release after 0A, with grant=00 for one cycle.
- Contention: req0 and req1 both valid from reset, each sending "X\n" repeatedly.
  - Grants alternate 01,10,01,10.
  - No byte of req1 appears between req0's 58 and 0A.
- MAX_BURST=4, req1 streams 8 bytes 00..07 with no EOL while req0 is waiting.
  - Release after byte 03.
  - Next grant goes to req0.
  - req1 resumes with 04 on its next grant.
- Timeout with IDLE_TIMEOUT=8: req0 sends one byte 41, then drops valid.
  - Release 8 cycles later.
  - Pending req1 is granted on the following cycle+1.
- Backpressure: tx_ready toggles 1,0,1,0 during a req0 line "HI\n".
  - req_ready[0] mirrors tx_ready.
  - Each byte appears exactly once.
  - burst_cnt increments only on handshakes.
- Reset mid-burst: assert rst_b=0 asynchronously after 2 bytes of a 5-byte line.
  - grant, tx_valid, req_ready and busy go 0 without waiting for a clock edge.
  - After reset release, req1 wins over req0 only if req0 is not valid, because the rr pointer is back at 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the default end-of-line byte and a constant-evaluable clog2 helper.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam logic [7:0] DEFAULT_EOL_CHAR = 8'h0A;

  // Smallest r with 2**r >= v; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << k) < 64'(v)) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: returns the first asserted request
// found when searching upward from i_ptr, wrapping modulo N.
// Ports:
//   i_req    [N-1:0]     request vector
//   i_ptr    [IDXW-1:0]  index with highest priority (must be < N)
//   o_onehot [N-1:0]     one-hot winner, zero when no request
//   o_idx    [IDXW-1:0]  winner index, zero when no request
//   o_any                at least one request present
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IDXW = clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [N-1:0]    o_onehot,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  logic [IDXW-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IDXW'((32'(i_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration with a line lock: once granted, a requester keeps
// the transmitter until it sends EOL_CHAR, reaches MAX_BURST bytes, or leaves
// valid low long enough to hit IDLE_TIMEOUT. One IDLE cycle separates grants.
// Ports:
//   clk        system clock
//   rst_b      asynchronous active-low reset
//   req_data   byte of requester i at [8i+7:8i]
//   req_valid  requester i has a byte
//   req_ready  byte of requester i accepted when req_valid[i] also high
//   tx_data    byte to the transmitter (0 while idle)
//   tx_valid   tx_data valid
//   tx_ready   transmitter can accept a byte
//   grant      one-hot current owner, zero when idle
//   busy       high while a requester owns the transmitter
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter logic [7:0]  EOL_CHAR     = DEFAULT_EOL_CHAR,
  parameter int unsigned MAX_BURST    = 80,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);

  localparam int unsigned IDXW = clog2(NUM_REQ);
  localparam int unsigned BW   = clog2(MAX_BURST + 1);
  localparam int unsigned IW   = clog2(IDLE_TIMEOUT);

  arb_state_t          r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
  logic [IDXW-1:0]     r_gidx, w_gidx_nxt;
  logic [IDXW-1:0]     r_ptr, w_ptr_nxt;
  logic [BW-1:0]       r_burst, w_burst_nxt, w_burst_inc;
  logic [IW-1:0]       r_idle, w_idle_nxt;

  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [IDXW-1:0]     w_pick_idx;
  logic                w_pick_any;

  logic [7:0]          w_own_data;
  logic                w_own_valid;
  logic                w_xfer;
  logic                w_release;

  rr_priority_picker #(
    .N    (NUM_REQ),
    .IDXW (IDXW)
  ) u_picker (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Owner's byte and valid, selected by the registered grant index.
  always_comb begin
    w_own_data  = '0;
    w_own_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDXW'(i) == r_gidx) begin
        w_own_data  = req_data[8*i +: 8];
        w_own_valid = req_valid[i];
      end
    end
  end

  // Pass-through to the transmitter; everything is gated by the registered
  // state so reset forces all handshake outputs low immediately.
  always_comb begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    req_ready = '0;
    if (r_state == ST_GRANT) begin
      tx_data   = w_own_data;
      tx_valid  = w_own_valid;
      req_ready = tx_ready ? r_grant : '0;
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state == ST_GRANT);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_burst_nxt = r_burst;
    w_idle_nxt  = r_idle;
    w_xfer      = 1'b0;
    w_release   = 1'b0;
    w_burst_inc = r_burst + 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick_onehot;
          w_gidx_nxt  = w_pick_idx;
          w_burst_nxt = '0;
          w_idle_nxt  = '0;
        end
      end
      ST_GRANT: begin
        w_xfer = w_own_valid && tx_ready;
        if (w_xfer) begin
          w_burst_nxt = w_burst_inc;
          w_idle_nxt  = '0;
          // EOL on the last allowed byte is still a single release.
          w_release   = (w_own_data == EOL_CHAR) ||
                        (w_burst_inc == BW'(MAX_BURST));
        end else begin
          if (!w_own_valid && (r_idle != IW'(IDLE_TIMEOUT - 1)))
            w_idle_nxt = r_idle + 1'b1;
          w_release = (r_idle == IW'(IDLE_TIMEOUT - 1));
        end
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_burst_nxt = '0;
          w_idle_nxt  = '0;
          w_ptr_nxt   = (r_gidx == IDXW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_burst <= w_burst_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

endmodule
